// File: rtl/range_frame_tx.sv
//------------------------------------------------------------------------------
// range_frame_tx : buffers host samples and emits one go/finish framed stream,
//                  computing the frame's max-min range for loopback self-check.
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module range_frame_tx #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       send,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       busy,
    output logic                       go,
    output logic                       finish,
    output logic [WIDTH-1:0]           data_out,
    output logic                       frame_done,
    output logic [WIDTH-1:0]           exp_range,
    output logic                       send_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GO     = 3'd1,
        STREAM = 3'd2,
        FIN    = 3'd3,
        GAP    = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [WIDTH-1:0]  mem_d [DEPTH];
    logic [CW-1:0]     count_q, count_d;
    logic [CW-1:0]     n_q, n_d;
    logic [CW-1:0]     idx_q, idx_d;
    logic [WIDTH-1:0]  max_q, max_d;
    logic [WIDTH-1:0]  min_q, min_d;
    logic [WIDTH-1:0]  exp_range_q, exp_range_d;
    logic [WIDTH-1:0]  data_out_q, data_out_d;
    logic              full_q, full_d;
    logic              busy_q, busy_d;
    logic              go_q, go_d;
    logic              finish_q, finish_d;
    logic              frame_done_q, frame_done_d;
    logic              send_err_q, send_err_d;
    logic [CW-1:0]     w_last;
    logic [CW-1:0]     w_penult;
    logic [AW-1:0]     w_rd_idx;
    logic [WIDTH-1:0]  w_sample;

    assign w_last   = n_q - CW'(1);
    assign w_penult = n_q - CW'(2);

    always_comb begin
        state_d      = state_q;
        mem_d        = mem_q;
        count_d      = count_q;
        n_d          = n_q;
        idx_d        = idx_q;
        max_d        = max_q;
        min_d        = min_q;
        exp_range_d  = exp_range_q;
        data_out_d   = '0;
        go_d         = 1'b0;
        finish_d     = 1'b0;
        frame_done_d = 1'b0;
        send_err_d   = 1'b0;
        w_rd_idx     = '0;
        w_sample     = '0;

        case (state_q)
            IDLE: begin
                // send sees the pre-write count; an accepted send drops the write
                if (send && (count_q >= CW'(2))) begin
                    state_d = GO;
                    n_d     = count_q;
                    idx_d   = '0;
                end else begin
                    send_err_d = send;
                    if (wr_en && !full_q) begin
                        mem_d[count_q[AW-1:0]] = wr_data;
                        count_d                = count_q + CW'(1);
                    end
                end
            end
            GO: begin
                if (n_q > CW'(2)) begin
                    state_d = STREAM;
                    idx_d   = CW'(1);
                end else begin
                    state_d = FIN;
                    idx_d   = w_last;
                end
            end
            STREAM: begin
                if (idx_q == w_penult) begin
                    state_d = FIN;
                    idx_d   = w_last;
                end else begin
                    idx_d   = idx_q + CW'(1);
                end
            end
            FIN: begin
                state_d     = GAP;
                exp_range_d = max_q - min_q;
                count_d     = '0;
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered, so they are derived from the state being entered
        w_rd_idx = idx_d[AW-1:0];
        w_sample = mem_q[w_rd_idx];
        if (state_d inside {GO, STREAM, FIN}) begin
            data_out_d = w_sample;
        end
        if (state_d == GO) begin
            max_d = w_sample;
            min_d = w_sample;
        end else if (state_d inside {STREAM, FIN}) begin
            if (w_sample > max_q) max_d = w_sample;
            if (w_sample < min_q) min_d = w_sample;
        end
        go_d         = (state_d == GO);
        finish_d     = (state_d == FIN);
        frame_done_d = (state_d == GAP);
        busy_d       = (state_d != IDLE);
        full_d       = (count_d == CW'(DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            count_q      <= '0;
            n_q          <= '0;
            idx_q        <= '0;
            max_q        <= '0;
            min_q        <= '0;
            exp_range_q  <= '0;
            data_out_q   <= '0;
            full_q       <= 1'b0;
            busy_q       <= 1'b0;
            go_q         <= 1'b0;
            finish_q     <= 1'b0;
            frame_done_q <= 1'b0;
            send_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_q        <= mem_d;
            count_q      <= count_d;
            n_q          <= n_d;
            idx_q        <= idx_d;
            max_q        <= max_d;
            min_q        <= min_d;
            exp_range_q  <= exp_range_d;
            data_out_q   <= data_out_d;
            full_q       <= full_d;
            busy_q       <= busy_d;
            go_q         <= go_d;
            finish_q     <= finish_d;
            frame_done_q <= frame_done_d;
            send_err_q   <= send_err_d;
        end
    end

    assign count      = count_q;
    assign full       = full_q;
    assign busy       = busy_q;
    assign go         = go_q;
    assign finish     = finish_q;
    assign data_out   = data_out_q;
    assign frame_done = frame_done_q;
    assign exp_range  = exp_range_q;
    assign send_err   = send_err_q;

endmodule

`default_nettype wire

// File: tb/tb_range_frame_tx.sv
//------------------------------------------------------------------------------
// tb_range_frame_tx : scoreboard bench for range_frame_tx.
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_range_frame_tx;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             wr_en = 1'b0;
    logic [WIDTH-1:0] wr_data = '0;
    logic             send = 1'b0;
    logic [CW-1:0]    count;
    logic             full, busy, go, finish, frame_done, send_err;
    logic [WIDTH-1:0] data_out, exp_range;

    range_frame_tx #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .send       (send),
        .count      (count),
        .full       (full),
        .busy       (busy),
        .go         (go),
        .finish     (finish),
        .data_out   (data_out),
        .frame_done (frame_done),
        .exp_range  (exp_range),
        .send_err   (send_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             rng;
        logic             go;
        logic             fin;
        logic [WIDTH-1:0] d;
    } exp_t;

    exp_t             sb[$];
    logic [WIDTH-1:0] mbuf[$];
    int               total = 0;
    int               bad = 0;
    longint           cyc = 0;
    longint           fin_cyc = 0;
    bit               have_fin = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Output monitor: every in-frame cycle pops one expected sample
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (go && finish) check("go_finish_together", 1, 0);
            if (busy && !frame_done) begin
                if (go && have_fin) check("finish_to_go_gap", 32'(cyc - fin_cyc >= 3), 1);
                if (finish) begin
                    fin_cyc  = cyc;
                    have_fin = 1;
                end
                if (sb.size() == 0 || sb[0].rng) begin
                    check("unexpected_sample", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("data_out", 32'(data_out), 32'(e.d));
                    check("go_flag", 32'(go), 32'(e.go));
                    check("finish_flag", 32'(finish), 32'(e.fin));
                end
            end else if (frame_done) begin
                if (sb.size() == 0 || !sb[0].rng) begin
                    check("unexpected_frame_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("exp_range", 32'(exp_range), 32'(e.d));
                end
            end else begin
                check("idle_outputs", {go, finish, data_out}, 0);
            end
        end
    end

    task automatic wr(input logic [WIDTH-1:0] v);
        wr_en   = 1'b1;
        wr_data = v;
        @(posedge clk); #1;
        wr_en = 1'b0;
        if (mbuf.size() < DEPTH) mbuf.push_back(v);
    endtask

    task automatic do_send();
        int               n;
        logic [WIDTH-1:0] mx, mn;
        exp_t             e;
        bit               acc;
        n   = mbuf.size();
        acc = (n >= 2);
        if (acc) begin
            mx = mbuf[0];
            mn = mbuf[0];
            for (int i = 0; i < n; i++) begin
                e.rng = 1'b0;
                e.go  = (i == 0);
                e.fin = (i == n - 1);
                e.d   = mbuf[i];
                sb.push_back(e);
                if (mbuf[i] > mx) mx = mbuf[i];
                if (mbuf[i] < mn) mn = mbuf[i];
            end
            e = '0;
            e.rng = 1'b1;
            e.d   = mx - mn;
            sb.push_back(e);
            mbuf.delete();
        end
        send = 1'b1;
        @(posedge clk); #1;
        send = 1'b0;
        if (acc) begin
            check("busy_after_send", 32'(busy), 1);
        end else begin
            check("send_err", 32'(send_err), 1);
            @(posedge clk); #1;
            check("send_err_pulse", 32'(send_err), 0);
            check("count_after_reject", 32'(count), 32'(mbuf.size()));
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("idle_timeout", 32'(busy), 0);
        check("scoreboard_drained", 32'(sb.size()), 0);
        check("count_cleared", 32'(count), 0);
    endtask

    task automatic frame3(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] rng);
        wr(a); wr(b); wr(c);
        do_send();
        wait_idle();
        check("frame3_range", 32'(exp_range), 32'(rng));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        check("rst_flags", {go, finish, busy, frame_done, send_err, full}, 0);
        check("rst_data_out", 32'(data_out), 0);
        check("rst_exp_range", 32'(exp_range), 0);
        check("rst_count", 32'(count), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Basic four-sample frame
        wr(10); wr(3); wr(25); wr(7);
        check("count_4", 32'(count), 4);
        do_send();
        wait_idle();
        check("range_22", 32'(exp_range), 22);

        // Single sample rejected, then a two-sample frame
        wr(42);
        do_send();
        wr(42);
        do_send();
        wait_idle();
        check("range_0", 32'(exp_range), 0);

        // Overfill
        for (int i = 0; i < 17; i++) begin
            wr(WIDTH'(i));
            if (i == 14) check("not_full_15", 32'(full), 0);
            if (i == 15) begin
                check("full_16", 32'(full), 1);
                check("count_16", 32'(count), 16);
            end
            if (i == 16) check("count_drop", 32'(count), 16);
        end
        do_send();
        wait_idle();
        check("range_15", 32'(exp_range), 15);

        // Writes and sends while busy are ignored
        wr(1); wr(2); wr(3); wr(4);
        do_send();
        wr_en   = 1'b1;
        wr_data = 99;
        send    = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        wr_en = 1'b0;
        send  = 1'b0;
        wait_idle();
        do_send();
        wr(50); wr(60);
        do_send();
        wait_idle();
        wr(70); wr(80);
        do_send();
        wait_idle();
        check("range_10", 32'(exp_range), 10);

        // Asynchronous reset mid-stream
        wr(1); wr(2); wr(3); wr(4); wr(5);
        do_send();
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("arst_flags", {go, finish, busy}, 0);
        check("arst_data_out", 32'(data_out), 0);
        check("arst_count", 32'(count), 0);
        sb.delete();
        mbuf.delete();
        have_fin = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        frame3(5, 200, 9, 195);

        // Loopback-style frames
        frame3(0, 255, 128, 255);
        frame3(8, 8, 8, 0);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
